// File: rtl/lfsr_8bit_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS (taps 8,6,5,4) generator and checker.
package lfsr_8bit_pkg;

    localparam int unsigned LFSR_W    = 8;
    localparam logic [7:0]  LFSR_SEED = 8'hFF;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } chk_state_t;

    // One step of the shared polynomial; both ends must call this.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lfsr_8bit_checker.sv
// Receive-side PRBS checker: seeds from the incoming stream, verifies LOCK_CNT
// consecutive words, then flywheels its own prediction and counts word/bit errors.
module lfsr_8bit_checker
    import lfsr_8bit_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [7:0]       data,
    input  logic             clr_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] bit_err_count,
    output logic             zero_seen
);

    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW  = $clog2(UNLOCK_CNT + 1);

    chk_state_t        state_q, state_d;
    logic [7:0]        expected_q, expected_d;
    logic [MatchW-1:0] match_cnt_q, match_cnt_d;
    logic [MissW-1:0]  miss_cnt_q, miss_cnt_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [ERR_W-1:0]  bit_err_count_q, bit_err_count_d;
    logic              zero_seen_q, zero_seen_d;

    logic [7:0]        diff;
    logic              is_match;
    logic [ERR_W:0]    bit_sum;

    assign diff     = data ^ expected_q;
    assign is_match = (diff == 8'h00);
    // One extra bit so the saturating add can detect overflow instead of wrapping.
    assign bit_sum  = {1'b0, bit_err_count_q} + {{(ERR_W - 3){1'b0}}, popcount8(diff)};

    // Next-state: FSM, expected-word prediction, lock/unlock counters and statistics.
    always_comb begin
        state_d         = state_q;
        expected_d      = expected_q;
        match_cnt_d     = match_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        err_pulse_d     = 1'b0;
        err_count_d     = err_count_q;
        bit_err_count_d = bit_err_count_q;
        zero_seen_d     = zero_seen_q;

        if (clk_en) begin
            if (data == 8'h00) begin
                zero_seen_d = 1'b1;
            end
            unique case (state_q)
                SEARCH: begin
                    if (data != 8'h00) begin
                        expected_d  = lfsr_next(data);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_match) begin
                        expected_d = lfsr_next(data);
                        if (match_cnt_q == MatchW'(LOCK_CNT - 1)) begin
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            state_d     = LOCKED;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        expected_d  = lfsr_next(data);
                        match_cnt_d = '0;
                        if (data == 8'h00) begin
                            state_d = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: the received word never reseeds the prediction here.
                    expected_d = lfsr_next(expected_q);
                    if (is_match) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        bit_err_count_d = bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
                        if (miss_cnt_q == MissW'(UNLOCK_CNT - 1)) begin
                            miss_cnt_d = '0;
                            state_d    = SEARCH;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Clear wins over a same-cycle error; err_pulse is left alone.
        if (clr_counts) begin
            err_count_d     = '0;
            bit_err_count_d = '0;
        end
    end

    assign locked_d = (state_d == LOCKED);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= SEARCH;
            expected_q      <= 8'h00;
            match_cnt_q     <= '0;
            miss_cnt_q      <= '0;
            locked_q        <= 1'b0;
            err_pulse_q     <= 1'b0;
            err_count_q     <= '0;
            bit_err_count_q <= '0;
            zero_seen_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            expected_q      <= expected_d;
            match_cnt_q     <= match_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            locked_q        <= locked_d;
            err_pulse_q     <= err_pulse_d;
            err_count_q     <= err_count_d;
            bit_err_count_q <= bit_err_count_d;
            zero_seen_q     <= zero_seen_d;
        end
    end

    assign locked        = locked_q;
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;
    assign bit_err_count = bit_err_count_q;
    assign zero_seen     = zero_seen_q;

endmodule

// File: tb/tb_lfsr_8bit_checker.sv
// Directed bench for lfsr_8bit_checker with hand-computed PRBS words from seed FF:
// FF FE FC F8 F0 E1 C2 85 0B 17 2F 5E BC 78 F1 E3 C6 8D 1A ...
module tb_lfsr_8bit_checker;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [7:0]  data;
    logic        clr_counts;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] bit_err_count;
    logic        zero_seen;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_8bit_checker #(
        .LOCK_CNT   (4),
        .UNLOCK_CNT (3),
        .ERR_W      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .data          (data),
        .clr_counts    (clr_counts),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .err_count     (err_count),
        .bit_err_count (bit_err_count),
        .zero_seen     (zero_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one word on the falling edge; return 1ns after the rising edge that samples it.
    task automatic send(input logic [7:0] d, input logic en, input logic clr);
        @(negedge clk);
        data       = d;
        clk_en     = en;
        clr_counts = clr;
        @(posedge clk);
        #1;
        clk_en     = 1'b0;
        clr_counts = 1'b0;
    endtask

    task automatic send_lock_prefix();
        send(8'hFF, 1'b1, 1'b0);
        send(8'hFE, 1'b1, 1'b0);
        send(8'hFC, 1'b1, 1'b0);
        send(8'hF8, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        clk_en     = 1'b0;
        data       = 8'h00;
        clr_counts = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_locked", {31'd0, locked}, 32'd0);
        check_eq("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        check_eq("rst_err_count", {16'd0, err_count}, 32'd0);
        check_eq("rst_bit_err", {16'd0, bit_err_count}, 32'd0);
        check_eq("rst_zero_seen", {31'd0, zero_seen}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: seed + 4 matches locks one cycle after F0
        send_lock_prefix();
        check_eq("t1_not_locked_after_F8", {31'd0, locked}, 32'd0);
        send(8'hF0, 1'b1, 1'b0);
        check_eq("t1_locked_after_F0", {31'd0, locked}, 32'd1);
        check_eq("t1_err_count", {16'd0, err_count}, 32'd0);
        check_eq("t1_zero_seen", {31'd0, zero_seen}, 32'd0);

        // 2: E1 corrupted to E0, then C2 accepted by the flywheel
        send(8'hE0, 1'b1, 1'b0);
        check_eq("t2_err_pulse", {31'd0, err_pulse}, 32'd1);
        check_eq("t2_err_count", {16'd0, err_count}, 32'd1);
        check_eq("t2_bit_err", {16'd0, bit_err_count}, 32'd1);
        check_eq("t2_locked", {31'd0, locked}, 32'd1);
        send(8'hC2, 1'b1, 1'b0);
        check_eq("t2_pulse_clear", {31'd0, err_pulse}, 32'd0);
        check_eq("t2_err_count_hold", {16'd0, err_count}, 32'd1);
        check_eq("t2_locked_hold", {31'd0, locked}, 32'd1);

        // 3: clear, then 85/0B/17 corrupted (8+2+1 bits) drops lock; relock on clean stream
        send(8'h00, 1'b0, 1'b1);
        check_eq("t3_clr", {16'd0, err_count}, 32'd0);
        send(8'h7A, 1'b1, 1'b0);
        check_eq("t3_locked_miss1", {31'd0, locked}, 32'd1);
        send(8'h08, 1'b1, 1'b0);
        check_eq("t3_locked_miss2", {31'd0, locked}, 32'd1);
        send(8'h16, 1'b1, 1'b0);
        check_eq("t3_unlocked_miss3", {31'd0, locked}, 32'd0);
        check_eq("t3_err_count", {16'd0, err_count}, 32'd3);
        check_eq("t3_bit_err", {16'd0, bit_err_count}, 32'd11);
        check_eq("t3_err_pulse", {31'd0, err_pulse}, 32'd1);
        send(8'h2F, 1'b1, 1'b0);
        check_eq("t3_search_no_pulse", {31'd0, err_pulse}, 32'd0);
        send(8'h5E, 1'b1, 1'b0);
        send(8'hBC, 1'b1, 1'b0);
        send(8'h78, 1'b1, 1'b0);
        check_eq("t3_not_yet_relocked", {31'd0, locked}, 32'd0);
        send(8'hF1, 1'b1, 1'b0);
        check_eq("t3_relocked", {31'd0, locked}, 32'd1);
        check_eq("t3_err_count_hold", {16'd0, err_count}, 32'd3);

        // 4: clk_en gaps carrying garbage must be ignored
        begin
            logic [7:0] gd [8];
            logic       ge [8];
            gd = '{8'hE3, 8'hAA, 8'hC6, 8'h00, 8'h55, 8'h8D, 8'hFF, 8'h1A};
            ge = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            for (int i = 0; i < 8; i++) begin
                send(gd[i], ge[i], 1'b0);
                check_eq($sformatf("t4_no_pulse_%0d", i), {31'd0, err_pulse}, 32'd0);
                check_eq($sformatf("t4_locked_%0d", i), {31'd0, locked}, 32'd1);
            end
        end
        check_eq("t4_err_count", {16'd0, err_count}, 32'd3);
        check_eq("t4_zero_seen", {31'd0, zero_seen}, 32'd0);

        // 5: async reset between edges, then all-zero word in SEARCH
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_locked", {31'd0, locked}, 32'd0);
        check_eq("t5_async_err_count", {16'd0, err_count}, 32'd0);
        check_eq("t5_async_bit_err", {16'd0, bit_err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h00, 1'b1, 1'b0);
        check_eq("t5_zero_seen", {31'd0, zero_seen}, 32'd1);
        check_eq("t5_zero_locked", {31'd0, locked}, 32'd0);
        send_lock_prefix();
        check_eq("t5_search_then_verify", {31'd0, locked}, 32'd0);
        send(8'hF0, 1'b1, 1'b0);
        check_eq("t5_relock", {31'd0, locked}, 32'd1);
        check_eq("t5_zero_sticky", {31'd0, zero_seen}, 32'd1);

        // 6: clear beats a simultaneous error; saturation of both counters
        send(8'hE0, 1'b1, 1'b0);
        check_eq("t6_pre_err_count", {16'd0, err_count}, 32'd1);
        send(8'hC3, 1'b1, 1'b1);
        check_eq("t6_clr_err_count", {16'd0, err_count}, 32'd0);
        check_eq("t6_clr_bit_err", {16'd0, bit_err_count}, 32'd0);
        check_eq("t6_clr_err_pulse", {31'd0, err_pulse}, 32'd1);
        send(8'h85, 1'b1, 1'b0);
        check_eq("t6_match_no_pulse", {31'd0, err_pulse}, 32'd0);
        force dut.err_count_q = 16'hFFFF;
        #1;
        release dut.err_count_q;
        send(8'hF4, 1'b1, 1'b0);
        check_eq("t6_err_sat", {16'd0, err_count}, 32'h0000FFFF);
        check_eq("t6_bit_err_8", {16'd0, bit_err_count}, 32'd8);
        force dut.bit_err_count_q = 16'hFFFC;
        #1;
        release dut.bit_err_count_q;
        send(8'hE8, 1'b1, 1'b0);
        check_eq("t6_bit_err_sat", {16'd0, bit_err_count}, 32'h0000FFFF);
        check_eq("t6_err_still_sat", {16'd0, err_count}, 32'h0000FFFF);
        check_eq("t6_locked", {31'd0, locked}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
